// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  // Arbiter FSM: accept a request, hold it on the memory port, report completion.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Watchdog limit used when the instantiating design does not override it.
  localparam int DEFAULT_TIMEOUT = 64;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: scans upward from ptr+1 (wrapping) and
// returns the first asserted request together with a found flag.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GRANT_W = grant_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] grant,
  output logic               any_valid
);

  // First valid requester after the last winner gets priority.
  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!any_valid && req[(int'(ptr) + i) % NUM_REQ]) begin
        any_valid = 1'b1;
        grant     = GRANT_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ masters.
//
// Handshake: a requester raises req_valid_i with its wr_rd_en/addr/wdata and
// holds it until req_ready_o pulses for one cycle; it must drop or change the
// request by the clock edge that ends that pulse, otherwise the still-valid
// request is treated as a new one. On the memory side mem_valid_o is held with
// stable mem_* fields until mem_ready_i is sampled high (or the watchdog
// expires); mem_rdata_i is only meaningful in the cycle mem_ready_i is high.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  localparam int GRANT_W   = grant_w(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ-1:0]            req_wr_rd_en_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [WIDTH-1:0]              req_rdata_o,
  output logic                          req_err_o,
  output logic                          mem_valid_o,
  output logic                          mem_wr_rd_en_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [WIDTH-1:0]              mem_wdata_o,
  input  logic [WIDTH-1:0]              mem_rdata_i,
  input  logic                          mem_ready_i,
  output logic [GRANT_W-1:0]            grant_id_o,
  output logic                          busy_o,
  output state_e                        dbg_state_o
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state;
  logic [GRANT_W-1:0] ptr;
  logic [GRANT_W-1:0] pick;
  logic               any_valid;
  logic [WD_W-1:0]    wd;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .GRANT_W (GRANT_W)
  ) u_pick (
    .req       (req_valid_i),
    .ptr       (ptr),
    .grant     (pick),
    .any_valid (any_valid)
  );

  assign dbg_state_o = state;

  // Arbitration FSM; the mem_* output registers double as the request latch.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state          <= IDLE;
      ptr            <= GRANT_W'(NUM_REQ - 1);
      wd             <= '0;
      req_ready_o    <= '0;
      req_rdata_o    <= '0;
      req_err_o      <= 1'b0;
      mem_valid_o    <= 1'b0;
      mem_wr_rd_en_o <= 1'b0;
      mem_addr_o     <= '0;
      mem_wdata_o    <= '0;
      grant_id_o     <= '0;
      busy_o         <= 1'b0;
    end else begin
      req_ready_o <= '0;
      req_err_o   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant_id_o     <= pick;
            mem_wr_rd_en_o <= req_wr_rd_en_i[pick];
            mem_addr_o     <= req_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata_o    <= req_wdata_i[int'(pick)*WIDTH +: WIDTH];
            mem_valid_o    <= 1'b1;
            busy_o         <= 1'b1;
            wd             <= '0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          wd <= wd + 1'b1;
          if (mem_ready_i) begin
            // Writes leave the last read data visible to requesters.
            if (!mem_wr_rd_en_o) begin
              req_rdata_o <= mem_rdata_i;
            end
            mem_valid_o <= 1'b0;
            req_ready_o <= NUM_REQ'(1) << grant_id_o;
            state       <= RESP;
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            mem_valid_o <= 1'b0;
            req_ready_o <= NUM_REQ'(1) << grant_id_o;
            req_err_o   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          ptr    <= grant_id_o;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_valid_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Self-checking bench for mem_rr_arbiter: a vector table of single
// transactions plus hand-written reset, round-robin, wait-state and timeout
// sequences, with completions checked against an expected queue.
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 32;
  localparam int AW      = 5;
  localparam int TIMEOUT = 8;
  localparam int GW      = 2;
  localparam int EW      = GW + 1 + WIDTH;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_wr_rd_en_i;
  logic [NUM_REQ*AW-1:0]    req_addr_i;
  logic [NUM_REQ*WIDTH-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [WIDTH-1:0]         req_rdata_o;
  logic                     req_err_o;
  logic                     mem_valid_o;
  logic                     mem_wr_rd_en_o;
  logic [AW-1:0]            mem_addr_o;
  logic [WIDTH-1:0]         mem_wdata_o;
  logic [WIDTH-1:0]         mem_rdata_i;
  logic                     mem_ready_i;
  logic [GW-1:0]            grant_id_o;
  logic                     busy_o;
  state_e                   dbg_state;

  mem_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_wr_rd_en_i (req_wr_rd_en_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_ready_o    (req_ready_o),
    .req_rdata_o    (req_rdata_o),
    .req_err_o      (req_err_o),
    .mem_valid_o    (mem_valid_o),
    .mem_wr_rd_en_o (mem_wr_rd_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ready_i    (mem_ready_i),
    .grant_id_o     (grant_id_o),
    .busy_o         (busy_o),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- memory model ----------------
  logic [WIDTH-1:0] mem [DEPTH];
  logic mem_en      = 1'b1;
  int   wait_cycles = 0;
  int   wait_cnt    = 0;

  assign mem_ready_i = mem_en && mem_valid_o && (wait_cnt == wait_cycles);
  assign mem_rdata_i = mem_ready_i ? mem[mem_addr_o] : '0;

  always @(posedge clk_i) begin
    if (!mem_valid_o || mem_ready_i) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
    if (mem_valid_o && mem_ready_i && mem_wr_rd_en_o) mem[mem_addr_o] <= mem_wdata_o;
  end

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int id, input logic err, input logic [WIDTH-1:0] rdata);
    logic [GW-1:0] gid;
    gid = id[GW-1:0];
    exp_q.push_back({gid, err, rdata});
  endtask

  int               issue_len      = 0;
  int               last_issue_len = 0;
  logic             cap_wr;
  logic [AW-1:0]    cap_addr;
  logic [WIDTH-1:0] cap_wdata;
  logic [EW-1:0]    mon_e;
  logic [GW-1:0]    mon_id;
  logic [3:0]       mon_oh;

  // Completion and memory-port monitor, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      issue_len = 0;
    end else begin
      if (req_ready_o != '0) begin
        last_issue_len = issue_len;
        issue_len      = 0;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_ready: got %b expected no pulse (cycle %0d)", req_ready_o, cyc);
        end else begin
          mon_e  = exp_q.pop_front();
          mon_id = mon_e[EW-1 -: GW];
          mon_oh = 4'b0001 << mon_id;
          check("ready_onehot", 32'(req_ready_o), 32'(mon_oh));
          check("grant_id", 32'(grant_id_o), 32'(mon_id));
          check("rdata", 32'(req_rdata_o), 32'(mon_e[WIDTH-1:0]));
          check("err", 32'(req_err_o), 32'(mon_e[WIDTH]));
        end
      end
      if (mem_valid_o) begin
        if (issue_len == 0) begin
          cap_wr    = mem_wr_rd_en_o;
          cap_addr  = mem_addr_o;
          cap_wdata = mem_wdata_o;
        end else begin
          check("mem_stable", 32'({mem_wr_rd_en_o, mem_addr_o, mem_wdata_o}),
                32'({cap_wr, cap_addr, cap_wdata}));
        end
        issue_len++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int k, input logic wr, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    req_valid_i[k]              = 1'b1;
    req_wr_rd_en_i[k]           = wr;
    req_addr_i[k*AW +: AW]      = a;
    req_wdata_i[k*WIDTH +: WIDTH] = d;
  endtask

  task automatic wait_pulse(output bit got, output int lat);
    got = 1'b0;
    lat = 0;
    while (!got && lat < 60) begin
      @(negedge clk_i);
      lat++;
      if (req_ready_o != '0) got = 1'b1;
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]       valid;
    logic             wr;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] wdata;
    int               grant;
    logic [WIDTH-1:0] rdata;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bit got;
    int lat;
    int pulse_cyc[$];

    req_valid_i    = '0;
    req_wr_rd_en_i = '0;
    req_addr_i     = '0;
    req_wdata_i    = '0;
    rst_i          = 1'b0;

    // Pointer starts at 3, so the table walks the picker through wraps.
    vecs[0]  = '{4'b0001, 1'b1, 5'd5,  16'hA5A5, 0, 16'h0000};
    vecs[1]  = '{4'b0001, 1'b0, 5'd5,  16'h0000, 0, 16'hA5A5};
    vecs[2]  = '{4'b1111, 1'b1, 5'd7,  16'h1234, 1, 16'hA5A5};
    vecs[3]  = '{4'b1001, 1'b0, 5'd7,  16'h0000, 3, 16'h1234};
    vecs[4]  = '{4'b0110, 1'b1, 5'd9,  16'hBEEF, 1, 16'h1234};
    vecs[5]  = '{4'b0110, 1'b0, 5'd9,  16'h0000, 2, 16'hBEEF};
    vecs[6]  = '{4'b0011, 1'b0, 5'd5,  16'h0000, 0, 16'hA5A5};
    vecs[7]  = '{4'b0001, 1'b1, 5'd31, 16'hFFFF, 0, 16'hA5A5};
    vecs[8]  = '{4'b1000, 1'b0, 5'd31, 16'h0000, 3, 16'hFFFF};
    vecs[9]  = '{4'b0100, 1'b1, 5'd0,  16'h0001, 2, 16'hFFFF};
    vecs[10] = '{4'b0010, 1'b0, 5'd0,  16'h0000, 1, 16'h0001};

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst_ctrl", 32'({mem_valid_o, req_ready_o, req_err_o, busy_o, grant_id_o, dbg_state}), 32'd0);
    check("rst_data", 32'({req_rdata_o, mem_wr_rd_en_o}), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Table-driven single transactions
    for (int v = 0; v < NV; v++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (vecs[v].valid[k]) set_req(k, vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      end
      push_exp(vecs[v].grant, 1'b0, vecs[v].rdata);
      wait_pulse(got, lat);
      req_valid_i = '0;
      check("vec_done", 32'(got), 32'd1);
      check("vec_latency", 32'(lat), 32'd2);
      @(negedge clk_i);
      check("vec_idle", 32'({busy_o, mem_valid_o}), 32'd0);
    end

    // Reset in the middle of an ISSUE: no pulse, outputs cleared immediately
    mem_en = 1'b0;
    set_req(1, 1'b0, 5'd9, 16'h0000);
    repeat (3) @(negedge clk_i);
    check("pre_rst_busy", 32'({busy_o, mem_valid_o, grant_id_o}), 32'b1101);
    #2 rst_i = 1'b0;
    #1;
    check("rst_async_ctrl", 32'({mem_valid_o, req_ready_o, req_err_o, busy_o, grant_id_o, dbg_state}), 32'd0);
    check("rst_async_data", 32'({req_rdata_o, mem_addr_o, mem_wr_rd_en_o}), 32'd0);
    req_valid_i = '0;
    mem_en      = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    // Round robin with every master requesting continuously
    for (int k = 0; k < NUM_REQ; k++) set_req(k, 1'b0, 5'd5, 16'h0000);
    for (int i = 0; i < 5; i++) push_exp(i % NUM_REQ, 1'b0, 16'hA5A5);
    for (int i = 0; i < 5; i++) begin
      wait_pulse(got, lat);
      check("rr_pulse", 32'(got), 32'd1);
      pulse_cyc.push_back(cyc);
      if (i == 0) check("rr_first_latency", 32'(lat), 32'd2);
    end
    req_valid_i = '0;
    for (int i = 1; i < 5; i++) check("rr_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'd3);
    @(negedge clk_i);

    // Wait states: memory answers in the sixth ISSUE cycle
    wait_cycles = 5;
    set_req(2, 1'b1, 5'd12, 16'h5A5A);
    push_exp(2, 1'b0, 16'hA5A5);
    wait_pulse(got, lat);
    req_valid_i = '0;
    @(negedge clk_i);
    check("ws_done", 32'(got), 32'd1);
    check("ws_issue_len", 32'(last_issue_len), 32'd6);
    check("ws_latency", 32'(lat), 32'd7);
    wait_cycles = 0;

    // Timeout: memory never answers
    mem_en = 1'b0;
    set_req(3, 1'b0, 5'd12, 16'h0000);
    push_exp(3, 1'b1, 16'hA5A5);
    wait_pulse(got, lat);
    req_valid_i = '0;
    @(negedge clk_i);
    check("to_done", 32'(got), 32'd1);
    check("to_issue_len", 32'(last_issue_len), 32'(TIMEOUT));
    check("to_latency", 32'(lat), 32'(TIMEOUT + 1));

    // Next request is served normally and reads the wait-state write
    mem_en = 1'b1;
    set_req(0, 1'b0, 5'd12, 16'h0000);
    push_exp(0, 1'b0, 16'h5A5A);
    wait_pulse(got, lat);
    req_valid_i = '0;
    check("post_to_done", 32'(got), 32'd1);
    check("post_to_latency", 32'(lat), 32'd2);

    repeat (3) @(negedge clk_i);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
